// File: rtl/rv32i_rf_pkg.sv
// Shared constants, requester encoding and hazard helper for the RV32I register-file writeback arbiter.
package rv32i_rf_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

    // A source is unreadable while a load is outstanding or while its write sits in the staging register.
    function automatic logic src_hazard(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [NUM_REGS-1:0]   busy,
        input logic                  we,
        input logic [REG_ADDR_W-1:0] wr
    );
        return (rs != REG_ZERO) && (busy[rs] || (we && (wr == rs)));
    endfunction

endpackage

// File: rtl/rf_wb_arb2.sv
// Two-way writeback arbiter (ALU vs LSU). RV32I_RF_WB_RR_EN selects round-robin tie-break,
// otherwise LSU wins ties with no grant history kept.
module rf_wb_arb2
    import rv32i_rf_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic alu_valid,
    input  logic lsu_valid,
    output logic alu_grant,
    output logic lsu_grant
);

`ifdef RV32I_RF_WB_RR_EN
    req_e last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_LSU;
        end else if (alu_grant) begin
            last_grant <= REQ_ALU;
        end else if (lsu_grant) begin
            last_grant <= REQ_LSU;
        end
    end

    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!reset) begin
            if (alu_valid && lsu_valid) begin
                alu_grant = (last_grant == REQ_LSU);
                lsu_grant = (last_grant == REQ_ALU);
            end else begin
                alu_grant = alu_valid;
                lsu_grant = lsu_valid;
            end
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk;

    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!reset) begin
            lsu_grant = lsu_valid;
            alu_grant = alu_valid && !lsu_valid;
        end
    end
`endif

endmodule

// File: rtl/rv32i_rf_wb_arbiter.sv
// Register-file write-port arbiter with load scoreboard and decode hazard detection.
// Tie-break policy is selected by RV32I_RF_WB_RR_EN inside rf_wb_arb2.
module rv32i_rf_wb_arbiter
    import rv32i_rf_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  issue_load,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_indata
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    rf_wb_arb2 u_arb (
        .clk       (sys_clk),
        .reset     (sys_reset),
        .alu_valid (alu_valid),
        .lsu_valid (lsu_valid),
        .alu_grant (alu_ready),
        .lsu_grant (lsu_ready)
    );

    // Accepted writes to x0 still move the index/data registers but never raise rf_we.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            rf_we     <= 1'b0;
            rf_rd     <= '0;
            rf_indata <= '0;
        end else if (alu_ready) begin
            rf_we     <= (alu_rd != REG_ZERO);
            rf_rd     <= alu_rd;
            rf_indata <= alu_data;
        end else if (lsu_ready) begin
            rf_we     <= (lsu_rd != REG_ZERO);
            rf_rd     <= lsu_rd;
            rf_indata <= lsu_data;
        end else begin
            rf_we     <= 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle reissue to the same index stays busy.
    always_comb begin
        busy_d = busy_q;
        if (lsu_ready) begin
            busy_d[lsu_rd] = 1'b0;
        end
        if (issue_load && (issue_rd != REG_ZERO)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_mask = busy_q;
    assign hazard    = src_hazard(rs1, busy_q, rf_we, rf_rd)
                     | src_hazard(rs2, busy_q, rf_we, rf_rd);

endmodule

// File: tb/tb_rv32i_rf_wb_arbiter.sv
// Self-checking bench for rv32i_rf_wb_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_rv32i_rf_wb_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        alu_valid, lsu_valid, issue_load;
    logic        alu_ready, lsu_ready, hazard, rf_we;
    logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1, rs2, rf_rd;
    logic [31:0] alu_data, lsu_data, rf_indata, busy_mask;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit        m_init = 0;
    bit [31:0] m_busy;
    bit        m_last_lsu;
    bit        m_we;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    bit        g_alu, g_lsu;

    always #5 sys_clk = ~sys_clk;

    rv32i_rf_wb_arbiter dut (
        .sys_clk    (sys_clk),
        .sys_reset  (sys_reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .issue_load (issue_load),
        .issue_rd   (issue_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard     (hazard),
        .busy_mask  (busy_mask),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_indata  (rf_indata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit src_blocked(input bit [4:0] rs);
        if (rs == 0) return 0;
        return m_busy[rs] || (m_we && m_rd == rs);
    endfunction

    // Expected grants for the current inputs, then compare, then advance the model across the edge.
    task automatic step();
        #2;
        g_alu = 0;
        g_lsu = 0;
        if (!sys_reset) begin
            if (alu_valid && lsu_valid) begin
`ifdef RV32I_RF_WB_RR_EN
                if (m_last_lsu) g_alu = 1; else g_lsu = 1;
`else
                g_lsu = 1;
`endif
            end else begin
                g_alu = alu_valid;
                g_lsu = lsu_valid;
            end
        end
        check("alu_ready", alu_ready, g_alu);
        check("lsu_ready", lsu_ready, g_lsu);
        if (m_init) begin
            check("rf_we", rf_we, m_we);
            if (m_we) begin
                check("rf_rd", rf_rd, m_rd);
                check("rf_indata", rf_indata, m_data);
            end
            check("busy_mask", busy_mask, m_busy);
            check("hazard", hazard, src_blocked(rs1) || src_blocked(rs2));
        end
        if (sys_reset) begin
            m_init = 1; m_busy = 0; m_we = 0; m_rd = 0; m_data = 0; m_last_lsu = 1;
        end else begin
            m_we = 0;
            if (g_alu) begin
                m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data; m_last_lsu = 0;
            end else if (g_lsu) begin
                m_we = (lsu_rd != 0); m_rd = lsu_rd; m_data = lsu_data; m_last_lsu = 1;
                m_busy[lsu_rd] = 0;
            end
            if (issue_load && issue_rd != 0) m_busy[issue_rd] = 1;
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        sys_reset = 0; alu_valid = 0; lsu_valid = 0; issue_load = 0;
    endtask

    task automatic do_reset();
        idle(); sys_reset = 1; step(); sys_reset = 0;
    endtask

    bit tie_alu [4];

    initial begin
        idle();
        alu_rd = 0; alu_data = 0; lsu_rd = 0; lsu_data = 0;
        issue_rd = 0; rs1 = 0; rs2 = 0;

        // reset held two cycles with a pending ALU request
        sys_reset = 1; alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        step(); step();
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_busy", busy_mask, 32'h0);
        sys_reset = 0;
        step();
        alu_valid = 0;
        #1;
        check("rst_rf_we1", rf_we, 1'b1);
        check("rst_rf_rd", rf_rd, 5'd5);
        check("rst_rf_data", rf_indata, 32'h1234);
        step();

        // tie-break from a fresh reset
`ifdef RV32I_RF_WB_RR_EN
        tie_alu = '{1, 0, 1, 0};
`else
        tie_alu = '{0, 0, 0, 0};
`endif
        do_reset();
        alu_valid = 1; lsu_valid = 1; alu_rd = 3; lsu_rd = 4;
        alu_data = 32'hA1; lsu_data = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tie_alu", alu_ready, tie_alu[i]);
            check("tie_lsu", lsu_ready, !tie_alu[i]);
            step();
        end
        idle(); step();

        // load hazard on x7
        issue_load = 1; issue_rd = 7; step();
        issue_load = 0; rs1 = 7;
        check("ld_busy7", busy_mask[7], 1'b1);
        #1 check("ld_haz_busy", hazard, 1'b1);
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hCAFE; step();
        lsu_valid = 0;
        check("ld_clr7", busy_mask[7], 1'b0);
        #1 check("ld_haz_staged", hazard, 1'b1);
        step();
        check("ld_haz_gone", hazard, 1'b0);
        rs1 = 0;

        // set/clear collision on x9
        issue_load = 1; issue_rd = 9; step();
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99; step();
        idle();
        check("coll_busy9", busy_mask[9], 1'b1);
        lsu_valid = 1; step(); idle(); step();

        // x0 handling
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
        #1 check("x0_ready", alu_ready, 1'b1);
        step(); idle();
        check("x0_we", rf_we, 1'b0);
        issue_load = 1; issue_rd = 0; step(); idle();
        check("x0_busy", busy_mask, 32'h0);
        rs1 = 0; rs2 = 0;
        #1 check("x0_haz", hazard, 1'b0);
        step();

        // mid-operation reset
        issue_load = 1; issue_rd = 7; step();
        issue_rd = 11; alu_valid = 1; alu_rd = 12; alu_data = 32'h55; step();
        idle();
        check("mid_busy", busy_mask, 32'h0000_0880);
        check("mid_we", rf_we, 1'b1);
        sys_reset = 1; alu_valid = 1; lsu_valid = 1; lsu_rd = 7;
        #1 check("mid_rdy_a", alu_ready, 1'b0);
        check("mid_rdy_l", lsu_ready, 1'b0);
        step();
        idle();
        check("mid_busy0", busy_mask, 32'h0);
        check("mid_we0", rf_we, 1'b0);
        step();

        // randomized traffic; requesters hold their request until granted
        for (int c = 0; c < 3000; c++) begin
            sys_reset = ($urandom_range(0, 199) == 0);
            if (!(alu_valid && !g_alu) || sys_reset) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!(lsu_valid && !g_lsu) || sys_reset) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = 5'($urandom_range(0, 15));
                lsu_data  = $urandom;
            end
            issue_load = ($urandom_range(0, 2) == 0);
            issue_rd   = 5'($urandom_range(0, 15));
            rs1        = 5'($urandom_range(0, 15));
            rs2        = 5'($urandom_range(0, 15));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_rf_wb_arbiter.md
Name: rv32i_rf_wb_arbiter

Overview:
- Shares the register file's single write port (rd/indata/we) between two writeback requesters: the execute unit (ALU) and the load/store unit (LSU).
- Tracks outstanding load destinations in a scoreboard and flags read hazards for decode (rs1/rs2).
- Sits between execute/LSU writeback and the RV32I register file. Its write outputs drive the register file's write-side inputs directly.

Parameters:
- XLEN, 32, data width of the write port.
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, architectural register count; index 0 is hardwired zero.

Ports:
- sys_clk  in  1  clock; all state updates on rising edge
- sys_reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU writeback accepted this cycle
- alu_rd  in  REG_ADDR_W  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_valid  in  1  load writeback request
- lsu_ready  out  1  load writeback accepted this cycle
- lsu_rd  in  REG_ADDR_W  load destination register
- lsu_data  in  XLEN  load result
- issue_load  in  1  a load is issued this cycle; marks issue_rd busy
- issue_rd  in  REG_ADDR_W  destination of the issued load
- rs1  in  REG_ADDR_W  decode source 1
- rs2  in  REG_ADDR_W  decode source 2
- hazard  out  1  rs1 or rs2 not yet readable; decode must stall
- busy_mask  out  NUM_REGS  scoreboard state; bit 0 always 0
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  REG_ADDR_W  register-file write index (registered)
- rf_indata  out  XLEN  register-file write data (registered)

Behaviour:
- Reset (sync, sys_reset=1 at edge):
  - rf_we=0, rf_rd=0, rf_indata=0.
  - busy_mask=0.
  - last_grant=LSU, so ALU wins the first tie.
  - While sys_reset=1, alu_ready=lsu_ready=0.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - ready is combinational from the valids and last_grant; it never depends on the requester's own ready.
  - At most one ready is high per cycle.
  - A requester holds valid, rd and data stable until accepted.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not in last_grant.
  - last_grant updates only on a transfer.
  - Neither valid: no grant; last_grant holds.
- Write stage, 1-cycle latency:
  - A transfer in cycle N gives rf_we=1, rf_rd=rd, rf_indata=data in cycle N+1.
  - The register file commits at the edge ending cycle N+1.
  - No transfer in cycle N gives rf_we=0 in N+1; rf_rd and rf_indata hold.
- rd==0: the transfer is accepted (ready asserted normally), but rf_we stays 0.
- Scoreboard:
  - Set: issue_load && issue_rd!=0 sets busy[issue_rd] at the edge.
  - Clear: an LSU transfer clears busy[lsu_rd] at the edge.
  - Set and clear on the same index in the same cycle: set wins.
  - Set on an already-busy index: stays busy.
  - ALU writes never touch the scoreboard.
- hazard (combinational), per source rsX, only when rsX!=0: hazard=1 if busy[rsX], or if rf_we && rf_rd==rsX (write staged but not yet committed).
- Throughput: one write per cycle sustained. Both requesters continuously valid alternate ALU, LSU, ALU, ...

Optional Feature:
- Macro: RV32I_RF_WB_RR_EN
- Defined: round-robin tie-break as described above.
- Undefined:
  - Fixed priority, LSU always wins ties.
  - last_grant register is removed.
  - The reset value statement for last_grant does not apply.
  - All other behaviour is identical.

Decomposition:
- Package rv32i_rf_pkg holds:
  - constants XLEN, REG_ADDR_W, NUM_REGS, REG_ZERO=0
  - requester encoding REQ_ALU=0, REQ_LSU=1
- One sub-module, rf_wb_arb2: a 2-way arbiter with last_grant state and the macro-selected policy.
- Scoreboard and write stage stay in the top module.

Test Plan:
- Reset: assert sys_reset 2 cycles while alu_valid=1 -> alu_ready=0, rf_we=0, busy_mask=0. After release, alu_rd=5, alu_data=0x1234 is accepted; the next cycle gives rf_we=1, rf_rd=5, rf_indata=0x1234.
- Tie-break: alu_valid=lsu_valid=1 for 4 cycles, alu_rd=3, lsu_rd=4.
  - With RV32I_RF_WB_RR_EN: grants ALU, LSU, ALU, LSU.
  - Without it: grants LSU on all 4 cycles.
- Load hazard:
  - issue_load, issue_rd=7 -> busy_mask[7]=1.
  - rs1=7 -> hazard=1.
  - LSU transfer lsu_rd=7 -> busy cleared next cycle. hazard stays 1 that cycle via staged rf_we/rf_rd=7, then 0.
- Set/clear collision: issue_load with issue_rd=9 in the same cycle as an LSU transfer with lsu_rd=9 (busy[9]=1 beforehand) -> busy[9]=1 after the edge.
- x0: alu_rd=0, alu_data=0xFFFFFFFF -> alu_ready=1, rf_we stays 0. issue_load with issue_rd=0 -> busy_mask=0. rs1=rs2=0 -> hazard=0.
- Mid-operation reset: busy_mask=0x00000880 and rf_we=1 pending; assert sys_reset one cycle -> next cycle busy_mask=0, rf_we=0, ready outputs low during reset.
